// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator: key indices, per-key FSM state
// encoding and the bounce LFSR.
package keypad_pkg;

  localparam int NUM_KEYS = 4;
  localparam int KEY_COL  = 3;

  localparam logic [1:0] KEY_LEFT   = 2'd0;
  localparam logic [1:0] KEY_RIGHT  = 2'd1;
  localparam logic [1:0] KEY_ATTACK = 2'd2;
  localparam logic [1:0] KEY_UP     = 2'd3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS_B = 2'd1,
    ST_HELD    = 2'd2,
    ST_REL_B   = 2'd3
  } key_state_e;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/keypad_key_fsm.sv
// One emulated key contact: IDLE -> PRESS_B -> HELD -> REL_B -> IDLE, with an
// 8-bit hold counter and an 8-bit bounce counter.
module keypad_key_fsm
  import keypad_pkg::*;
#(
  parameter int BOUNCE_CYC = 8,
  parameter bit BOUNCE_EN  = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       cmd_fire_i,
  input  logic [7:0] cmd_hold_i,
  input  logic       release_all_i,
  input  logic       bounce_bit_i,
  output logic       pressed_o,
  output logic       busy_o,
  output key_state_e state_o
);

  localparam logic [7:0] BOUNCE_LEN = 8'(BOUNCE_CYC);

  key_state_e state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] bounce_q, bounce_d;
  logic       start;

  // A zero-length hold is accepted by the handshake but does nothing.
  assign start = cmd_fire_i && (cmd_hold_i != 8'd0);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      hold_q   <= 8'd0;
      bounce_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      bounce_q <= bounce_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    bounce_d = bounce_q;
    case (state_q)
      ST_IDLE: begin
        if (!release_all_i && start) begin
          hold_d = cmd_hold_i;
          if (BOUNCE_EN) begin
            state_d  = ST_PRESS_B;
            bounce_d = BOUNCE_LEN;
          end else begin
            state_d = ST_HELD;
          end
        end
      end
      ST_PRESS_B: begin
        if (release_all_i) begin
          state_d  = ST_REL_B;
          bounce_d = BOUNCE_LEN;
        end else begin
          if (start) hold_d = cmd_hold_i;
          if (bounce_q <= 8'd1) state_d = ST_HELD;
          else                  bounce_d = bounce_q - 8'd1;
        end
      end
      ST_HELD: begin
        if (release_all_i || (!start && hold_q <= 8'd1)) begin
          hold_d = 8'd0;
          if (BOUNCE_EN) begin
            state_d  = ST_REL_B;
            bounce_d = BOUNCE_LEN;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (start) begin
          hold_d = cmd_hold_i;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      ST_REL_B: begin
        // A new press during release bounce starts the press over.
        if (!release_all_i && start) begin
          hold_d = cmd_hold_i;
          if (BOUNCE_EN) begin
            state_d  = ST_PRESS_B;
            bounce_d = BOUNCE_LEN;
          end else begin
            state_d = ST_HELD;
          end
        end else if (bounce_q <= 8'd1) begin
          state_d  = ST_IDLE;
          bounce_d = 8'd0;
        end else begin
          bounce_d = bounce_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    pressed_o = 1'b0;
    case (state_q)
      ST_PRESS_B, ST_REL_B: pressed_o = bounce_bit_i;
      ST_HELD:              pressed_o = 1'b1;
      default:              pressed_o = 1'b0;
    endcase
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign state_o = state_q;

endmodule

// File: rtl/keypad_emulator.sv
// Emulates four keys on column 3 of a scanned active-low keypad matrix, with
// optional LFSR-driven contact bounce on press and release.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int BOUNCE_CYC = 8,
  parameter bit BOUNCE_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_key,
  input  logic [7:0] cmd_hold,
  input  logic       release_all,
  output logic [3:0] pressed,
  output logic       busy,
  output logic [7:0] dbg_state
);

  // Handshake: a command transfers on any cycle where cmd_valid && cmd_ready;
  // cmd_ready is low only while rst_n is low, so no command is ever stalled.
  logic        accept;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  key_pressed;
  logic [3:0]  key_busy;
  logic        unused_cols;

  assign cmd_ready   = rst_n;
  assign accept      = cmd_valid && cmd_ready;
  assign lfsr_d      = lfsr_next(lfsr_q);
  assign unused_cols = ^cols[2:0];

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_state_e key_state;

    keypad_key_fsm #(
      .BOUNCE_CYC(BOUNCE_CYC),
      .BOUNCE_EN (BOUNCE_EN)
    ) u_key (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .cmd_fire_i   (accept && (cmd_key == 2'(k))),
      .cmd_hold_i   (cmd_hold),
      .release_all_i(release_all),
      .bounce_bit_i (lfsr_q[k]),
      .pressed_o    (key_pressed[k]),
      .busy_o       (key_busy[k]),
      .state_o      (key_state)
    );

    assign dbg_state[2*k +: 2] = key_state;
  end

  // Masking with rst_n keeps the matrix released during reset even before the
  // key FSMs have been cleared by the reset edge.
  assign pressed = key_pressed & {4{rst_n}};
  assign rows    = ~(pressed & {4{~cols[KEY_COL]}});
  assign busy    = |key_busy;

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter BOUNCE_CYC, default 8: length in clk cycles of each emulated contact-bounce phase (1..255).
REQ-002 Parameter BOUNCE_EN, default 1: 1 enables bounce phases; 0 makes press and release clean single-edge transitions.
REQ-003 clk  input  1  single system clock; all state updates on posedge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 cols  input  4  active-low column scan from the keypad scanner.
REQ-006 rows  output  4  active-low row return lines to the keypad scanner.
REQ-007 cmd_valid  input  1  press command present this cycle.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-009 cmd_key  input  2  key select: 0 LEFT, 1 RIGHT, 2 ATTACK, 3 UP.
REQ-010 cmd_hold  input  8  HELD duration in clk cycles.
REQ-011 release_all  input  1  force release of every key.
REQ-012 pressed  output  4  per-key emulated contact state, bit k = key k, active-high.
REQ-013 busy  output  1  high while any key is outside IDLE.

Function
REQ-014 Key k SHALL sit on column 3 and row k: LEFT row0, RIGHT row1, ATTACK row2, UP row3.
REQ-015 rows[k] SHALL equal NOT(pressed[k] AND NOT cols[3]), combinationally and with zero latency from cols; rows SHALL be 4'b1111 whenever cols[3]=1, whatever the other cols bits are.
REQ-016 cmd_ready SHALL be 1 in every cycle except reset cycles.
REQ-017 Each key SHALL have an independent FSM with states IDLE, PRESS_B, HELD, REL_B, plus an 8-bit hold counter and an 8-bit bounce counter.
REQ-018 IDLE: pressed=0; an accepted cmd SHALL load the hold counter from cmd_hold and go to PRESS_B (BOUNCE_EN=1) or HELD (BOUNCE_EN=0).
REQ-019 PRESS_B: pressed = current LFSR bit k; after BOUNCE_CYC cycles go to HELD.
REQ-020 HELD: pressed=1; the hold counter decrements each cycle; when the counter is 1, go to REL_B (BOUNCE_EN=1) or IDLE (BOUNCE_EN=0) on the next edge, so HELD lasts exactly cmd_hold cycles.
REQ-021 REL_B: pressed = LFSR bit k; after BOUNCE_CYC cycles go to IDLE with pressed=0.
REQ-022 A command with cmd_hold=0 SHALL be accepted with no state change.
REQ-023 A command to a key in PRESS_B or HELD SHALL reload its hold counter and leave its state unchanged.
REQ-024 A command to a key in REL_B SHALL restart PRESS_B (or go to HELD if BOUNCE_EN=0).
REQ-025 release_all=1 SHALL move every key in PRESS_B or HELD to REL_B (or to IDLE if BOUNCE_EN=0) on the next edge, and SHALL take priority over a command arriving in the same cycle.
REQ-026 Bounce source: one 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1, advancing every cycle; key k uses bit k.
REQ-027 busy SHALL be the OR over all keys of (state != IDLE).

Reset
REQ-028 While rst_n=0 at a posedge: all FSMs go to IDLE, counters to 0, and the LFSR to its seed; pressed=0, busy=0, cmd_ready=0.
REQ-029 rows SHALL be 4'b1111 while rst_n=0, regardless of cols.
REQ-030 Reset asserted mid-press SHALL abort the press immediately, with no release bounce.

Structure
REQ-031 Key index constants (KEY_LEFT..KEY_UP = 0..3) and the FSM state encoding SHALL live in a shared package keypad_pkg.
REQ-032 The per-key FSM with its counters SHALL be sub-module keypad_key_fsm, instantiated four times; the LFSR and row mux stay in the top level.

Verification
REQ-033 BOUNCE_EN=0, cmd LEFT hold=5, cols=4'b0111 -> rows=4'b1110 for exactly 5 cycles starting the edge after acceptance, then 4'b1111.
REQ-034 Same press held, cols=4'b1011 -> rows=4'b1111 throughout; cols=4'b0110 -> rows=4'b1110.
REQ-035 BOUNCE_EN=1, BOUNCE_CYC=8, cmd UP hold=10 -> pressed[3] follows LFSR bit3 for 8 cycles, is 1 for 10 cycles, follows LFSR bit3 for 8 cycles, then 0; busy is high for all 26 cycles.
REQ-036 RIGHT in HELD with 3 cycles left, new cmd RIGHT hold=20 -> HELD continues for 20 more cycles with no gap in pressed[1].
REQ-037 ATTACK and UP both HELD, release_all plus cmd LEFT in the same cycle -> ATTACK and UP enter REL_B, LEFT stays IDLE.
REQ-038 rst_n=0 for 1 cycle while any key is HELD -> next cycle pressed=0, busy=0, rows=4'b1111, and the LFSR restarts from 16'hACE1.
